// File: rtl/router_pkg.sv
// Shared constants for the multicast router: width defaults and the broadcast ID.
package router_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ID_WIDTH_DEF   = 8;
  localparam int ID_WIDTH_MAX   = 32;

  // All-ones destination; sliced down to the configured ID width by the router.
  localparam logic [ID_WIDTH_MAX-1:0] BCAST_ID = '1;

endpackage

// File: rtl/router_fifo.sv
// Show-ahead per-channel FIFO: the head word is visible on dout whenever not empty.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // An empty FIFO shows zero so stale storage never leaks onto the PE port.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/router_mc.sv
// Multicast bus-to-PE router with per-channel programmable IDs and FIFOs.
// Define ROUTER_MC_BCAST_EN to make the all-ones destination ID reach every channel.
module router_mc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         config_state,
  input  logic                         ce,
  input  logic [CW-1:0]                cfg_ch,
  input  logic [ID_WIDTH-1:0]          cfg_id,
  input  logic [ID_WIDTH-1:0]          bus_dest_id,
  input  logic [DATA_WIDTH-1:0]        bus_data_in,
  input  logic                         bus_data_valid,
  output logic                         bus_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] pe_data_out,
  output logic [NUM_CH-1:0]            pe_data_valid,
  input  logic [NUM_CH-1:0]            pe_data_ready
);

  logic [NUM_CH-1:0][ID_WIDTH-1:0] own_id;
  logic [NUM_CH-1:0]               match;
  logic [NUM_CH-1:0]               full;
  logic [NUM_CH-1:0]               empty;
  logic [NUM_CH-1:0]               push;
  logic [NUM_CH-1:0]               pop;
  logic                            accept;

  // Out-of-range cfg_ch values simply match no loop index and are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) own_id[c] <= ID_WIDTH'(c);
    end else if (ce && config_state) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_ch == CW'(c)) own_id[c] <= cfg_id;
      end
    end
  end

`ifdef ROUTER_MC_BCAST_EN
  logic is_bcast;
  assign is_bcast = (bus_dest_id == BCAST_ID[ID_WIDTH-1:0]);
`endif

  always_comb begin
    match = '0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef ROUTER_MC_BCAST_EN
      match[c] = (bus_dest_id == own_id[c]) | is_bcast;
`else
      match[c] = (bus_dest_id == own_id[c]);
`endif
    end
  end

  // All-or-nothing: any matched channel that is full stalls the whole bus word.
  assign bus_ready     = ~rst & ce & ~config_state & (&(~match | ~full));
  assign accept        = bus_data_valid & bus_ready;
  assign push          = {NUM_CH{accept}} & match;
  assign pe_data_valid = ~empty & {NUM_CH{ce}};
  assign pop           = pe_data_valid & pe_data_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    router_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[c]),
      .pop  (pop[c]),
      .din  (bus_data_in),
      .dout (pe_data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .full (full[c]),
      .empty(empty[c])
    );
  end

endmodule

// File: tb/tb_router_mc.sv
// Scoreboard bench for router_mc: directed bus words, per-channel expected queues.
module tb_router_mc;

  logic        clk;
  logic        rst;
  logic        config_state;
  logic        ce;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_id;
  logic [7:0]  bus_dest_id;
  logic [15:0] bus_data_in;
  logic        bus_data_valid;
  logic        bus_ready;
  logic [31:0] pe_data_out;
  logic [1:0]  pe_data_valid;
  logic [1:0]  pe_data_ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  router_mc #(
    .DATA_WIDTH(16),
    .ID_WIDTH  (8),
    .NUM_CH    (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .config_state  (config_state),
    .ce            (ce),
    .cfg_ch        (cfg_ch),
    .cfg_id        (cfg_id),
    .bus_dest_id   (bus_dest_id),
    .bus_data_in   (bus_data_in),
    .bus_data_valid(bus_data_valid),
    .bus_ready     (bus_ready),
    .pe_data_out   (pe_data_out),
    .pe_data_valid (pe_data_valid),
    .pe_data_ready (pe_data_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: each negedge with valid&ready is exactly one pop at the next edge.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        if (pe_data_valid[c] && pe_data_ready[c]) begin
          checks++;
          if ((c == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            errors++;
            $display("[TB] FAIL ch%0d_unexpected: got %h expected no word", c, pe_data_out[c*16 +: 16]);
          end else begin
            exp = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (pe_data_out[c*16 +: 16] !== exp) begin
              errors++;
              $display("[TB] FAIL ch%0d_data: got %h expected %h", c, pe_data_out[c*16 +: 16], exp);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [1:0] mask, input logic [15:0] data);
    if (mask[0]) exp_q0.push_back(data);
    if (mask[1]) exp_q1.push_back(data);
  endtask

  // Presents one bus word and waits (bounded) for it to be taken.
  task automatic applyStimulus(input logic [7:0] dest, input logic [15:0] data,
                               input logic [1:0] mask, input int max_wait);
    bit done;
    done           = 1'b0;
    bus_dest_id    = dest;
    bus_data_in    = data;
    bus_data_valid = 1'b1;
    for (int i = 0; i < max_wait && !done; i++) begin
      @(negedge clk);
      if (bus_ready) done = 1'b1;
      tick();
    end
    bus_data_valid = 1'b0;
    if (done) pushExpected(mask, data);
    else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept of %h", data);
    end
  endtask

  task automatic configId(input logic [0:0] ch, input logic [7:0] id);
    config_state = 1'b1;
    cfg_ch       = ch;
    cfg_id       = id;
    tick();
    config_state = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    pe_data_ready = 2'b11;
    for (int i = 0; i < max_cycles && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) tick();
    tick();
    checkOutput("drain_q0", exp_q0.size(), 0);
    checkOutput("drain_q1", exp_q1.size(), 0);
  endtask

  initial begin
    rst            = 1'b1;
    ce             = 1'b1;
    config_state   = 1'b0;
    cfg_ch         = '0;
    cfg_id         = '0;
    bus_dest_id    = '0;
    bus_data_in    = '0;
    bus_data_valid = 1'b0;
    pe_data_ready  = 2'b00;
    #2;
    checkOutput("reset_bus_ready", bus_ready, 0);
    checkOutput("reset_pe_valid", pe_data_valid, 0);
    checkOutput("reset_pe_data", pe_data_out, 0);
    tick();
    tick();
    rst = 1'b0;

    // Unicast to channel 1
    config_state = 1'b1;
    @(negedge clk);
    checkOutput("config_blocks_bus", bus_ready, 0);
    tick();
    configId(1'b0, 8'h05);
    configId(1'b1, 8'h06);
    applyStimulus(8'h06, 16'hABCD, 2'b10, 4);
    @(negedge clk);
    checkOutput("unicast_valid", pe_data_valid, 2'b10);
    checkOutput("unicast_data", pe_data_out, 32'hABCD_0000);
    tick();
    waitDrain(20);

    // Channel 0 backpressure: 5th word waits for one pop
    pe_data_ready = 2'b10;
    for (int i = 0; i < 4; i++) applyStimulus(8'h05, 16'h1001 + 16'(i), 2'b01, 4);
    bus_dest_id    = 8'h05;
    bus_data_in    = 16'h1005;
    bus_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("full_blocks", bus_ready, 0);
    tick();
    pe_data_ready = 2'b11;
    @(negedge clk);
    checkOutput("full_no_bypass", bus_ready, 0);
    tick();
    pe_data_ready = 2'b10;
    @(negedge clk);
    checkOutput("after_pop_ready", bus_ready, 1);
    tick();
    bus_data_valid = 1'b0;
    pushExpected(2'b01, 16'h1005);
    waitDrain(20);

    // Shared ID: full ch1 blocks delivery to both
    pe_data_ready = 2'b00;
    configId(1'b1, 8'h07);
    for (int i = 0; i < 4; i++) applyStimulus(8'h07, 16'h2001 + 16'(i), 2'b10, 4);
    configId(1'b0, 8'h07);
    bus_dest_id    = 8'h07;
    bus_data_in    = 16'h3333;
    bus_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("mc_blocked", bus_ready, 0);
    checkOutput("mc_no_partial", pe_data_valid, 2'b10);
    tick();
    @(negedge clk);
    checkOutput("mc_still_no_partial", pe_data_valid, 2'b10);
    tick();
    pe_data_ready = 2'b10;
    @(negedge clk);
    checkOutput("mc_pop_cycle_blocked", bus_ready, 0);
    tick();
    pe_data_ready = 2'b00;
    @(negedge clk);
    checkOutput("mc_unblocked", bus_ready, 1);
    tick();
    bus_data_valid = 1'b0;
    pushExpected(2'b11, 16'h3333);
    @(negedge clk);
    checkOutput("mc_both_valid", pe_data_valid, 2'b11);
    tick();
    waitDrain(20);

    // All-ones destination
`ifdef ROUTER_MC_BCAST_EN
    pe_data_ready = 2'b00;
    applyStimulus(8'hFF, 16'h1234, 2'b11, 4);
    @(negedge clk);
    checkOutput("bcast_valid", pe_data_valid, 2'b11);
    checkOutput("bcast_data", pe_data_out, 32'h1234_1234);
    tick();
    waitDrain(20);
`else
    pe_data_ready  = 2'b11;
    bus_dest_id    = 8'hFF;
    bus_data_in    = 16'h1234;
    bus_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("nomatch_accepted", bus_ready, 1);
    tick();
    bus_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("nomatch_discarded", pe_data_valid, 2'b00);
    tick();
    waitDrain(20);
`endif

    // Block disable holds state and blocks both sides
    pe_data_ready = 2'b00;
    applyStimulus(8'h07, 16'h4444, 2'b11, 4);
    ce             = 1'b0;
    bus_dest_id    = 8'h07;
    bus_data_in    = 16'h5555;
    bus_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("ce0_valid", pe_data_valid, 2'b00);
    checkOutput("ce0_bus_ready", bus_ready, 0);
    tick();
    bus_data_valid = 1'b0;
    ce             = 1'b1;
    @(negedge clk);
    checkOutput("ce1_valid_restored", pe_data_valid, 2'b11);
    tick();
    waitDrain(20);

    // Reset mid-operation
    pe_data_ready = 2'b00;
    for (int i = 0; i < 3; i++) applyStimulus(8'h07, 16'h6001 + 16'(i), 2'b11, 4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", pe_data_valid, 2'b00);
    checkOutput("midrst_bus_ready", bus_ready, 0);
    checkOutput("midrst_data", pe_data_out, 0);
    exp_q0.delete();
    exp_q1.delete();
    tick();
    rst            = 1'b0;
    pe_data_ready  = 2'b11;
    bus_dest_id    = 8'h01;
    bus_data_in    = 16'h7777;
    bus_data_valid = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_accept", bus_ready, 1);
    tick();
    bus_data_valid = 1'b0;
    pushExpected(2'b10, 16'h7777);
    applyStimulus(8'h00, 16'h8888, 2'b01, 4);
    applyStimulus(8'h07, 16'h9999, 2'b00, 4);
    waitDrain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_mc.md
ROUTER_MC -- requirements
Module: router_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width per word.
REQ-002 SHALL have parameter ID_WIDTH, default 8, destination/channel ID width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of PE output channels (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, words per channel FIFO (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port config_state  input  1  1 = ID configuration mode.
REQ-008 SHALL have port ce  input  1  block enable.
REQ-009 SHALL have port cfg_ch  input  max(1,$clog2(NUM_CH))  channel whose ID is written.
REQ-010 SHALL have port cfg_id  input  ID_WIDTH  ID value written in config mode.
REQ-011 SHALL have port bus_dest_id  input  ID_WIDTH  destination ID of the bus word.
REQ-012 SHALL have port bus_data_in  input  DATA_WIDTH  bus payload.
REQ-013 SHALL have port bus_data_valid  input  1  bus word present.
REQ-014 SHALL have port bus_ready  output  1  bus word accepted this cycle when high with valid.
REQ-015 SHALL have port pe_data_out  output  NUM_CH*DATA_WIDTH  per-channel head word, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port pe_data_valid  output  NUM_CH  per-channel head word valid.
REQ-017 SHALL have port pe_data_ready  input  NUM_CH  per-channel PE consume.

Function
REQ-018 SHALL, when ce=1 and config_state=1, write cfg_id into own_id[cfg_ch] at the next edge; cfg_ch >= NUM_CH ignored.
REQ-019 SHALL compute match[c] = (bus_dest_id == own_id[c]) combinationally; several channels may match (multicast).
REQ-020 SHALL drive bus_ready = ce & ~config_state & AND over c of (~match[c] | ~full[c]); all-or-nothing delivery.
REQ-021 SHALL, on bus_data_valid & bus_ready, push bus_data_in into every matched channel FIFO; a word matching no channel is accepted and discarded.
REQ-022 SHALL pop channel c on pe_data_valid[c] & pe_data_ready[c]; pops continue during config_state when ce=1.
REQ-023 SHALL present pushed word on pe_data_out one cycle after the push edge (show-ahead, no same-cycle bypass when empty).
REQ-024 SHALL derive full from stored count only; push on full is blocked even if the same cycle pops (no ready-to-ready combinational path).
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 SHALL, when ce=0, hold all state, drive bus_ready=0 and pe_data_valid=0.

Reset
REQ-027 SHALL on rst=1 asynchronously empty all FIFOs, set own_id[c]=c, bus_ready=0, pe_data_valid=0, pe_data_out=0.
REQ-028 SHALL discard FIFO contents on reset mid-operation; first accept possible the cycle after rst deasserts.

Configuration
REQ-029 SHALL, with ROUTER_MC_BCAST_EN defined, treat bus_dest_id = all-ones as matching every channel; without it, all-ones is an ordinary ID.

Structure
REQ-030 SHALL place ID/data width defaults and the broadcast ID constant in shared package router_pkg.
REQ-031 SHALL instantiate one sub-module router_fifo per channel (show-ahead FIFO with push, pop, full, empty).

Verification
REQ-032 Config own_id[0]=0x05, own_id[1]=0x06; send 0xABCD to 0x06 -> pe_data_valid=2'b10, ch1 data 0xABCD one cycle later.
REQ-033 pe_data_ready[0]=0, send 4 words to 0x05 -> bus_ready=0 on 5th; one ch0 pop -> 5th accepted next cycle.
REQ-034 Both channels ID 0x07, ch1 full, send to 0x07 -> bus_ready=0, no push into ch0; drain ch1 -> word lands in both.
REQ-035 With ROUTER_MC_BCAST_EN, send 0x1234 to 0xFF -> both channels output 0x1234; without macro -> discarded, bus_ready=1.
REQ-036 Assert rst with 3 words in ch0 -> pe_data_valid=0 immediately, own_id restored to 0,1.
